// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: a small byte FIFO feeds an 11-bit framer that
// drives the PS/2 clock and data lines open-drain and resends on host inhibit.
module ps2_device_tx #(
  parameter int HALF_PERIOD = 1120,
  parameter int IDLE_CYC    = 1400,
  parameter int SETTLE      = 28,
  parameter int FIFO_AW     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_wr,
  output logic       fifo_full,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_abort
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CMAX  = (HALF_PERIOD > IDLE_CYC) ? HALF_PERIOD : IDLE_CYC;
  localparam int CW    = $clog2(CMAX + 1);

  localparam logic [CW-1:0]      HP_LAST   = CW'(HALF_PERIOD - 1);
  localparam logic [CW-1:0]      IDLE_LAST = CW'(IDLE_CYC - 1);
  localparam logic [CW-1:0]      SETTLE_C  = CW'(SETTLE);
  localparam logic [FIFO_AW:0]   FULL_CNT  = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BUS,
    SEND,
    DONE,
    ABORT
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [3:0]        bit_idx;
  logic              phase_low;

  logic              clk_s1, clk_s2, data_s1, data_s2;

  logic [7:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]  count;
  logic              push, pop;
  logic [7:0]        head;
  logic [10:0]       frame;

  // Synchronisers idle at the released (pulled-up) bus level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2clk_in;
      clk_s2  <= clk_s1;
      data_s1 <= ps2data_in;
      data_s2 <= data_s1;
    end
  end

  assign fifo_full = (count == FULL_CNT);
  assign push      = data_wr & ~fifo_full;
  assign pop       = (state == DONE) && (cnt == HP_LAST);
  assign head      = mem[rd_ptr];
  assign frame     = {1'b1, ~^head, head, 1'b0};
  assign busy      = (state != IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      phase_low  <= 1'b0;
      ps2clk_oe  <= 1'b0;
      ps2data_oe <= 1'b0;
      tx_done    <= 1'b0;
      tx_abort   <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_abort <= 1'b0;
      case (state)
        IDLE: begin
          ps2clk_oe  <= 1'b0;
          ps2data_oe <= 1'b0;
          if (count != '0) begin
            state <= WAIT_BUS;
            cnt   <= '0;
          end
        end
        WAIT_BUS: begin
          // Data low with clock high is a host request-to-send: never start then.
          if (clk_s2 && data_s2) begin
            if (cnt == IDLE_LAST) begin
              state      <= SEND;
              cnt        <= '0;
              bit_idx    <= '0;
              phase_low  <= 1'b0;
              ps2clk_oe  <= 1'b0;
              ps2data_oe <= ~frame[0];
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            cnt <= '0;
          end
        end
        SEND: begin
          if (!phase_low) begin
            if (cnt >= SETTLE_C && !clk_s2) begin
              state      <= ABORT;
              cnt        <= '0;
              ps2clk_oe  <= 1'b0;
              ps2data_oe <= 1'b0;
              tx_abort   <= 1'b1;
            end else if (cnt == HP_LAST) begin
              phase_low <= 1'b1;
              ps2clk_oe <= 1'b1;
              cnt       <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else if (cnt == HP_LAST) begin
            ps2clk_oe <= 1'b0;
            cnt       <= '0;
            if (bit_idx == 4'd10) begin
              state      <= DONE;
              ps2data_oe <= 1'b0;
            end else begin
              bit_idx    <= bit_idx + 4'd1;
              phase_low  <= 1'b0;
              ps2data_oe <= ~frame[bit_idx + 4'd1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (cnt == HP_LAST) begin
            state   <= IDLE;
            cnt     <= '0;
            tx_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ABORT: begin
          state <= WAIT_BUS;
          cnt   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
